// File: rtl/johnson_seq_ctrl.sv
// Run controller for an N-stage Johnson ring used as a 2N-phase sequencer: runs
// num_cycles full rotations with hold/abort and recovers from illegal ring codes.
module johnson_seq_ctrl #(
   parameter int N     = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_cycles,
   input  logic             dir,
   input  logic             hold,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [1:0]       fsm_state,
   output logic [N-1:0]     jc_state,
   output logic [2*N-1:0]   phase,
   output logic [CNT_W-1:0] rot_cnt
);
   localparam int PW = 2 * N;
   localparam int KW = $clog2(PW);
   localparam int TW = $clog2(N) + 1;
   localparam logic [KW:0] TWO_N = (KW+1)'(PW);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] num_lat;
   logic [CNT_W-1:0] rot_inc;
   logic             dir_lat;
   logic             illegal;
   logic             accept;
   logic             step;
   logic             wrap;
   logic [N-1:0]     jc_next;
   logic [TW-1:0]    trans;
   logic [KW-1:0]    pop;
   logic [KW-1:0]    idx;

   // A legal Johnson code has at most one boundary between its run of ones and zeros.
   always_comb begin
      trans = '0;
      for (int j = 0; j < N-1; j++) begin
         trans = trans + TW'(jc_state[j] ^ jc_state[j+1]);
      end
      illegal = (trans > TW'(1));
   end

   always_comb begin
      pop = '0;
      for (int j = 0; j < N; j++) begin
         pop = pop + KW'(jc_state[j]);
      end
      if (jc_state[0]) begin
         idx = pop;
      end else if (pop == '0) begin
         idx = '0;
      end else begin
         idx = KW'(TWO_N - {1'b0, pop});
      end
      phase = PW'(1) << idx;
   end

   always_comb begin
      jc_next = dir_lat ? {~jc_state[0], jc_state[N-1:1]}
                        : {jc_state[N-2:0], ~jc_state[N-1]};
      rot_inc = rot_cnt + CNT_W'(1);
      accept  = ((state == IDLE) || (state == DONE)) && start && !abort && !illegal;
      step    = (state == RUN) && !hold && !abort && !illegal;
      wrap    = step && (jc_next == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Illegal-code recovery outranks abort, which outranks everything the host asks for.
   always_comb begin
      next_state = state;
      if (illegal || abort) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  next_state = (num_cycles != '0) ? RUN : DONE;
               end else begin
                  next_state = IDLE;
               end
            end
            RUN: begin
               if (hold) begin
                  next_state = PAUSE;
               end else if (wrap && (rot_inc == num_lat)) begin
                  next_state = DONE;
               end
            end
            PAUSE: begin
               if (!hold) begin
                  next_state = RUN;
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

   always_comb begin
      busy      = (state == RUN) || (state == PAUSE);
      done      = (state == DONE);
      fsm_state = state;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         jc_state <= '0;
         rot_cnt  <= '0;
         num_lat  <= '0;
         dir_lat  <= 1'b0;
         err      <= 1'b0;
      end else begin
         err <= illegal;
         if (illegal || (abort && (state != IDLE))) begin
            jc_state <= '0;
         end else if (accept) begin
            jc_state <= '0;
            rot_cnt  <= '0;
            num_lat  <= num_cycles;
            dir_lat  <= dir;
         end else if (step) begin
            jc_state <= jc_next;
            if (wrap) begin
               rot_cnt <= rot_inc;
            end
         end
      end
   end

endmodule
